// File: rtl/dff_pipe.sv
// Elastic WIDTH-bit register pipeline of DEPTH stages with valid/ready on both sides.
// Latency: DEPTH-1 cycles from input capture to q when unstalled (DEPTH=1: visible right after capture).
// Backpressure: ready ripples back through full stages only; empty stages always accept, so bubbles collapse.
module dff_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           d,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           q,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] r [DEPTH];
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic             push;
    logic             pop;

    // Stage i can advance if the consumer takes q or any stage from i to the output is empty.
    // Written as a flat scan rather than a recursive chain so no signal feeds back on itself.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                if (!v[j]) begin
                    rdy[i] = 1'b1;
                end
            end
        end
    end

    // Upstream source for each stage: stage 0 sees the producer, others see the previous stage.
    always_comb begin
        up_v[0] = in_valid;
        up_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = v[i-1];
            up_d[i] = r[i-1];
        end
    end

    // Handshake outputs; flush and reset block both sides so nothing transfers during them.
    always_comb begin
        in_ready  = rdy[0] && !flush && !rst;
        out_valid = v[DEPTH-1] && !flush && !rst;
        q         = r[DEPTH-1];
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Valid bits: cleared by reset or flush, otherwise each ready stage takes its upstream valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= up_v[i];
                end
            end
        end
    end

    // Data regs: loaded only when a valid entry moves in; flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r[i] <= RESET_VAL;
            end
        end else if (!flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i] && up_v[i]) begin
                    r[i] <= up_d[i];
                end
            end
        end
    end

    // Occupancy: registered, moves only on push-without-pop or pop-without-push.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: a DEPTH=3 and a DEPTH=1 instance.
// Expected output items are queued as stimulus is issued; negedge monitors pop and compare on each transfer.
// Cycle-exact properties (latency, count, ready gating) are checked inline after each edge.
module tb_dff_pipe;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] d3, q3;
    logic       iv3, ir3, ov3, or3, fl3;
    logic [1:0] cnt3;

    logic [7:0] d1, q1;
    logic       iv1, ir1, ov1, or1, fl1;
    logic [0:0] cnt1;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp3 [$];
    logic [7:0] exp1 [$];
    logic [7:0] e3, e1;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut3 (
        .clk(clk), .rst(rst), .d(d3), .in_valid(iv3), .in_ready(ir3),
        .q(q3), .out_valid(ov3), .out_ready(or3), .flush(fl3), .count(cnt3)
    );

    dff_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h3C)) dut1 (
        .clk(clk), .rst(rst), .d(d1), .in_valid(iv1), .in_ready(ir1),
        .q(q1), .out_valid(ov1), .out_ready(or1), .flush(fl1), .count(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output monitor for the DEPTH=3 instance: every transfer must match the next expected item.
    always @(negedge clk) begin
        if (ov3 && or3) begin
            checks++;
            if (exp3.size() == 0) begin
                failures++;
                $display("FAIL q3_unexpected: got %0h expected no item", q3);
            end else begin
                e3 = exp3.pop_front();
                if (q3 !== e3) begin
                    failures++;
                    $display("FAIL q3_order: got %0h expected %0h", q3, e3);
                end
            end
        end
    end

    // Output monitor for the DEPTH=1 instance.
    always @(negedge clk) begin
        if (ov1 && or1) begin
            checks++;
            if (exp1.size() == 0) begin
                failures++;
                $display("FAIL q1_unexpected: got %0h expected no item", q1);
            end else begin
                e1 = exp1.pop_front();
                if (q1 !== e1) begin
                    failures++;
                    $display("FAIL q1_order: got %0h expected %0h", q1, e1);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        d3 = 8'h00; iv3 = 1'b0; or3 = 1'b0; fl3 = 1'b0;
        d1 = 8'h00; iv1 = 1'b0; or1 = 1'b0; fl1 = 1'b0;

        // Reset held for two edges
        tick();
        chk("rst_in_ready", ir3, 0);
        tick();
        chk("rst_out_valid", ov3, 0);
        chk("rst_q", q3, 8'hA5);
        chk("rst_count", cnt3, 0);
        chk("rst_in_ready2", ir3, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", ir3, 1);

        // Streaming with out_ready high
        or3 = 1'b1;
        d3 = 8'h11; iv3 = 1'b1; exp3.push_back(8'h11);
        tick();
        d3 = 8'h22; exp3.push_back(8'h22);
        tick();
        d3 = 8'h33; exp3.push_back(8'h33);
        tick();
        iv3 = 1'b0;
        chk("stream_q0", q3, 8'h11);
        chk("stream_v0", ov3, 1);
        chk("stream_cnt0", cnt3, 3);
        tick();
        chk("stream_q1", q3, 8'h22);
        chk("stream_v1", ov3, 1);
        chk("stream_cnt1", cnt3, 2);
        tick();
        chk("stream_q2", q3, 8'h33);
        chk("stream_v2", ov3, 1);
        chk("stream_cnt2", cnt3, 1);
        tick();
        chk("stream_empty_v", ov3, 0);
        chk("stream_empty_cnt", cnt3, 0);

        // Backpressure until full, then simultaneous push and pop
        or3 = 1'b0;
        d3 = 8'h01; iv3 = 1'b1; exp3.push_back(8'h01);
        tick();
        d3 = 8'h02; exp3.push_back(8'h02);
        tick();
        d3 = 8'h03; exp3.push_back(8'h03);
        tick();
        d3 = 8'h04;
        #1;
        chk("full_in_ready", ir3, 0);
        chk("full_cnt", cnt3, 3);
        chk("full_q", q3, 8'h01);
        tick();
        chk("full_hold_in_ready", ir3, 0);
        chk("full_hold_cnt", cnt3, 3);
        chk("full_hold_q", q3, 8'h01);
        or3 = 1'b1;
        #1;
        chk("full_release_in_ready", ir3, 1);
        exp3.push_back(8'h04);
        tick();
        iv3 = 1'b0;
        chk("pushpop_cnt", cnt3, 3);
        chk("pushpop_q", q3, 8'h02);
        tick();
        tick();
        tick();
        chk("full_drain_cnt", cnt3, 0);
        chk("full_drain_v", ov3, 0);

        // Bubble collapse under backpressure
        or3 = 1'b0;
        d3 = 8'hB1; iv3 = 1'b1; exp3.push_back(8'hB1);
        tick();
        iv3 = 1'b0;
        tick();
        tick();
        d3 = 8'hB2; iv3 = 1'b1; exp3.push_back(8'hB2);
        tick();
        iv3 = 1'b0;
        #1;
        chk("bubble_cnt", cnt3, 2);
        chk("bubble_in_ready", ir3, 1);
        chk("bubble_q", q3, 8'hB1);
        chk("bubble_v", ov3, 1);
        tick();
        chk("bubble_compact_q", q3, 8'hB1);
        chk("bubble_compact_cnt", cnt3, 2);
        or3 = 1'b1;
        tick();
        chk("bubble_next_q", q3, 8'hB2);
        chk("bubble_next_v", ov3, 1);
        chk("bubble_next_cnt", cnt3, 1);
        tick();
        chk("bubble_done_v", ov3, 0);
        chk("bubble_done_cnt", cnt3, 0);

        // Flush mid-stream: flushed items must never be transferred
        or3 = 1'b0;
        d3 = 8'hE1; iv3 = 1'b1;
        tick();
        d3 = 8'hE2;
        tick();
        iv3 = 1'b0;
        tick();
        chk("preflush_cnt", cnt3, 2);
        chk("preflush_v", ov3, 1);
        fl3 = 1'b1; iv3 = 1'b1; d3 = 8'hCC; or3 = 1'b1;
        #1;
        chk("flush_in_ready", ir3, 0);
        chk("flush_out_valid", ov3, 0);
        tick();
        fl3 = 1'b0; iv3 = 1'b0;
        #1;
        chk("postflush_cnt", cnt3, 0);
        chk("postflush_v", ov3, 0);
        tick();
        tick();
        tick();
        chk("postflush_idle_v", ov3, 0);
        chk("postflush_idle_cnt", cnt3, 0);

        // Reset wins over flush with the pipeline full
        or3 = 1'b0;
        d3 = 8'hF1; iv3 = 1'b1;
        tick();
        d3 = 8'hF2;
        tick();
        d3 = 8'hF3;
        tick();
        iv3 = 1'b0;
        chk("prerst_cnt", cnt3, 3);
        chk("prerst_q", q3, 8'hF1);
        rst = 1'b1; fl3 = 1'b1;
        tick();
        rst = 1'b0; fl3 = 1'b0;
        #1;
        chk("rstflush_q", q3, 8'hA5);
        chk("rstflush_cnt", cnt3, 0);
        chk("rstflush_v", ov3, 0);
        chk("rstflush_in_ready", ir3, 1);

        // DEPTH=1 instance: same-edge visibility and full-rate streaming
        chk("d1_rst_q", q1, 8'h3C);
        or1 = 1'b1;
        d1 = 8'h5A; iv1 = 1'b1; exp1.push_back(8'h5A);
        tick();
        chk("d1_lat_q", q1, 8'h5A);
        chk("d1_lat_v", ov1, 1);
        chk("d1_lat_cnt", cnt1, 1);
        d1 = 8'h5B; exp1.push_back(8'h5B);
        tick();
        chk("d1_pushpop_q", q1, 8'h5B);
        chk("d1_pushpop_cnt", cnt1, 1);
        iv1 = 1'b0;
        tick();
        chk("d1_empty_v", ov1, 0);
        chk("d1_empty_cnt", cnt1, 0);
        or1 = 1'b0;
        d1 = 8'h77; iv1 = 1'b1; exp1.push_back(8'h77);
        tick();
        chk("d1_stall_in_ready", ir1, 0);
        chk("d1_stall_q", q1, 8'h77);
        iv1 = 1'b0; or1 = 1'b1;
        tick();
        chk("d1_drain_cnt", cnt1, 0);
        chk("d1_drain_v", ov1, 0);

        // Every expected item must have been seen by the monitors
        for (int k = 0; k < 20 && (exp3.size() != 0 || exp1.size() != 0); k++) begin
            tick();
        end
        chk("drain_exp3", exp3.size(), 0);
        chk("drain_exp1", exp1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
